// File: rtl/float_quantizer_stream.sv
// Streaming FP32 quantizer: maps each sample to the index of the first programmable
// threshold it strictly exceeds, through a 2-stage valid/ready pipeline.
module float_quantizer_stream #(
    parameter int NUM_THR = 9,
    parameter int LVL_W   = 4,
    parameter int ADDR_W  = 4,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [31:0]       cfg_wdata,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LVL_W-1:0]  out_level,
    output logic              out_nan,
    output logic [CNT_W-1:0]  out_count
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // in_ready depends only on the output stage, never on in_valid.

    logic [31:0]        r_thr [NUM_THR];
    logic [NUM_THR-1:0] r_s1_gt;
    logic               r_s1_nan;
    logic               r_s1_valid;
    logic               r_out_valid;
    logic [LVL_W-1:0]   r_out_level;
    logic               r_out_nan;
    logic [CNT_W-1:0]   r_count;

    logic               w_advance;
    logic               w_accept;
    logic               w_in_nan;
    logic [NUM_THR-1:0] w_gt;
    logic [LVL_W-1:0]   w_level;

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    // Strict a > b on raw FP32 bits; NaN never compares greater, +0 equals -0.
    function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
        if (is_nan(a) || is_nan(b))
            return 1'b0;
        if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0))
            return 1'b0;
        if (a[31] != b[31])
            return !a[31];
        if (!a[31])
            return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    assign w_advance = !r_out_valid || out_ready;
    assign w_accept  = in_valid && w_advance;
    assign w_in_nan  = is_nan(in_data);

    always_comb begin
        w_gt = '0;
        for (int i = 0; i < NUM_THR; i++)
            w_gt[i] = fp_gt(in_data, r_thr[i]);
    end

    // Lowest index wins, so scan from the top down and let lower hits overwrite.
    always_comb begin
        w_level = LVL_W'(NUM_THR);
        for (int i = NUM_THR - 1; i >= 0; i--)
            if (r_s1_gt[i])
                w_level = LVL_W'(i);
    end

    // Compares above read the pre-edge thresholds, so a same-edge write only affects later samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_THR; i++)
                r_thr[i] <= 32'h0000_0000;
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_THR; i++)
                if (cfg_addr == ADDR_W'(i))
                    r_thr[i] <= cfg_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_gt     <= '0;
            r_s1_nan    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_level <= '0;
            r_out_nan   <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid  <= w_accept;
            if (w_accept) begin
                r_s1_gt  <= w_gt;
                r_s1_nan <= w_in_nan;
            end
            r_out_valid <= r_s1_valid;
            r_out_level <= w_level;
            r_out_nan   <= r_s1_nan;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (r_out_valid && out_ready)
            r_count <= r_count + CNT_W'(1);
    end

    assign in_ready  = w_advance;
    assign out_valid = r_out_valid;
    assign out_level = r_out_level;
    assign out_nan   = r_out_nan;
    assign out_count = r_count;

endmodule

// File: tb/tb_float_quantizer_stream.sv
// Directed bench for float_quantizer_stream: expected {nan, level} pushed on accept,
// popped and compared on each output handshake.
module tb_float_quantizer_stream;

    localparam int NUM_THR = 9;
    localparam int LVL_W   = 4;
    localparam int ADDR_W  = 4;
    localparam int CNT_W   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [ADDR_W-1:0] cfg_addr = '0;
    logic [31:0]       cfg_wdata = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [LVL_W-1:0]  out_level;
    logic              out_nan;
    logic [CNT_W-1:0]  out_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [LVL_W:0] exp_q[$];
    int             lat_q[$];
    logic [CNT_W-1:0] exp_cnt = '0;

    float_quantizer_stream #(
        .NUM_THR(NUM_THR), .LVL_W(LVL_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_level(out_level), .out_nan(out_nan), .out_count(out_count)
    );

    // Clock / cycle counter
    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Monitor / scoreboard: compare on the falling edge, transfer happens on the next rising edge.
    always @(negedge clk) begin
        logic [LVL_W:0] e;
        int             a;
        if (rst) begin
            exp_cnt = '0;
        end else begin
            chk("count", 32'(out_count), 32'(exp_cnt));
            if (out_valid && out_ready) begin
                chk("out_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    a = lat_q.pop_front();
                    chk("level", 32'(out_level), 32'(e[LVL_W-1:0]));
                    chk("nan", 32'(out_nan), 32'(e[LVL_W]));
                    if (a >= 0)
                        chk("latency", 32'(cyc - a), 32'd2);
                end
                exp_cnt = exp_cnt + 1'b1;
            end
        end
    end

    // Drivers
    task automatic cfg_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic nan, input int lvl, input bit lat);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(in_ready), 32'd1);
        exp_q.push_back({nan, LVL_W'(lvl)});
        lat_q.push_back(lat ? cyc : -1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] thr [NUM_THR];
        thr = '{32'h3F638EF3, 32'h3F2AAAE3, 32'h3EE38E4C, 32'h3E638DA4, 32'h00000000,
                32'hBE638DA4, 32'hBEE38E4C, 32'hBF2AAAE3, 32'hBF638EF3};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_level", 32'(out_level), 32'd0);
        chk("rst_out_nan", 32'(out_nan), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Out-of-range address must be ignored, then program the table
        cfg_write(ADDR_W'(9), 32'h7F7FFFFF);
        cfg_write(ADDR_W'(15), 32'h7F7FFFFF);
        for (int i = 0; i < NUM_THR; i++)
            cfg_write(ADDR_W'(i), thr[i]);

        // Main stream with latency checking
        send(32'h3F800000, 1'b0, 0, 1'b1);
        send(32'h3F000000, 1'b0, 2, 1'b1);
        send(32'h3F2AAAE3, 1'b0, 2, 1'b1);
        send(32'h00000000, 1'b0, 5, 1'b1);
        send(32'h80000000, 1'b0, 5, 1'b1);
        send(32'hBF800000, 1'b0, 9, 1'b1);
        drain();
        chk("count_six", 32'(out_count), 32'd6);

        // Special values
        send(32'h7FC00000, 1'b1, 9, 1'b1);
        send(32'h7F800000, 1'b0, 0, 1'b1);
        send(32'hFF800000, 1'b0, 9, 1'b1);
        send(32'h00000001, 1'b0, 4, 1'b1);
        send(32'h80000001, 1'b0, 5, 1'b1);
        send(32'h7F800001, 1'b1, 9, 1'b1);
        drain();

        // Backpressure
        out_ready = 1'b0;
        fork
            begin
                send(32'h3F800000, 1'b0, 0, 1'b0);
                send(32'h3E800000, 1'b0, 3, 1'b0);
                send(32'hBF000000, 1'b0, 7, 1'b0);
                send(32'h3F400000, 1'b0, 1, 1'b0);
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_valid_seen", 32'(out_valid), 32'd1);
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_in_ready", 32'(in_ready), 32'd0);
                    chk("bp_out_valid", 32'(out_valid), 32'd1);
                    chk("bp_level_hold", 32'(out_level), 32'd0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Same-edge config write does not affect the sample accepted on that edge
        cfg_we = 1'b1; cfg_addr = ADDR_W'(1); cfg_wdata = 32'h3E800000;
        send(32'h3F000000, 1'b0, 2, 1'b1);
        cfg_we = 1'b0;
        send(32'h3F000000, 1'b0, 1, 1'b1);
        drain();

        // Reset with two samples in flight
        send(32'h3F800000, 1'b0, 0, 1'b0);
        send(32'h3F800000, 1'b0, 0, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        lat_q.delete();
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_count", 32'(out_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        send(32'h3F800000, 1'b0, 0, 1'b1);
        send(32'h00000001, 1'b0, 0, 1'b1);
        send(32'h00000000, 1'b0, 9, 1'b1);
        send(32'h80000001, 1'b0, 9, 1'b1);
        drain();

        // Counter wrap: 17 deliveries from zero -> 1 with a 4-bit counter
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 17; i++)
            send($urandom_range(32'h7F7FFFFF, 32'h00000001), 1'b0, 0, 1'b0);
        drain();
        chk("count_wrap", 32'(out_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/float_quantizer_stream.md
Name: float_quantizer_stream

Overview:
- Streaming FP32-to-level quantizer for the HDC encoder front end; replaces the fixed 9-threshold combinational/registered quantizer.
- Holds NUM_THR run-time programmable FP32 thresholds; maps each accepted sample to a level index that feeds the level-hypervector LUT.
- Valid/ready on input and output, 2-stage pipeline, NaN flagging, delivered-sample counter.

Parameters:
- NUM_THR, 9: number of thresholds; output levels 0..NUM_THR.
- LVL_W, 4: output level width; must satisfy 2**LVL_W > NUM_THR.
- ADDR_W, 4: config address width; must satisfy 2**ADDR_W >= NUM_THR.
- CNT_W, 32: width of delivered-sample counter.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  threshold write strobe
- cfg_addr  in  ADDR_W  threshold index; writes with cfg_addr >= NUM_THR are ignored
- cfg_wdata  in  32  FP32 threshold value
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample this cycle
- in_data  in  32  FP32 input sample
- out_valid  out  1  output level valid
- out_ready  in  1  downstream accepts the output
- out_level  out  LVL_W  quantized level
- out_nan  out  1  sample was NaN (exp=0xFF, mant!=0)
- out_count  out  CNT_W  number of outputs delivered (out_valid && out_ready)

Behaviour:
- Reset (async, rst=1): all thresholds=0x00000000, both stage valids=0, out_valid=0, out_level=0, out_nan=0, out_count=0, in_ready=1 after release.
- FP32 greater-than, a>b (strict): false if either operand is NaN. +0 and -0 compare equal. Otherwise use sign-magnitude ordering on the raw bits; denormals and infinities are ordered by that same rule. No FP arithmetic.
- Level encoding (priority): level = smallest i in 0..NUM_THR-1 with in_data > thr[i]; NUM_THR if none. Thresholds are intended descending; the priority rule defines the result for any programming. NaN input gives level NUM_THR and out_nan=1.
- Pipeline: advance = !out_valid || out_ready; in_ready = advance (combinational, no dependency on in_valid).
- Stage 1: on accept (in_valid && in_ready) register the NUM_THR compare bits and the NaN bit; s1_valid follows accept whenever advance=1.
- Stage 2: on advance, encode stage-1 bits into out_level/out_nan; out_valid <= s1_valid.
- Latency: 2 cycles from accept to out_valid with no backpressure. Throughput 1 sample/cycle.
- Stall: while out_valid && !out_ready, out_level, out_nan, out_valid and stage 1 all hold.
- Config coherence: the compare for a sample accepted at edge k uses threshold values before any write taking effect at edge k. Writes never disturb in-flight samples. Writes are allowed every cycle, independent of the handshake.
- out_count increments by 1 on each out_valid && out_ready edge and wraps 2**CNT_W-1 -> 0.
- Reset mid-operation drops in-flight samples immediately; no output is produced for them.

Test Plan:
- Program thr[0..8] = 3F638EF3, 3F2AAAE3, 3EE38E4C, 3E638DA4, 00000000, BE638DA4, BEE38E4C, BF2AAAE3, BF638EF3. Stream 3F800000, 3F000000, 3F2AAAE3, 00000000, 80000000, BF800000 with out_ready=1 -> levels 0, 2, 2, 5, 5, 9, each 2 cycles after accept. out_count ends at 6.
- Input 7FC00000 (NaN) -> level 9, out_nan=1. Input 7F800000 (+inf) -> level 0, out_nan=0. Input FF800000 (-inf) -> level 9, out_nan=0.
- Backpressure: stream 4 samples, hold out_ready=0 for 5 cycles -> in_ready=0 once out_valid is set, out_level stable. Release -> all 4 delivered in order, no loss or duplication.
- Config race: in the same cycle, accept 3F000000 and write thr[1]=3E800000 -> that sample gives 2. The next identical sample gives 1.
- Reset: assert rst with 2 samples in flight -> out_valid=0 and out_count=0 immediately, no stale output after release, thresholds read back as 0 (any positive input -> level 0).
- Counter wrap with CNT_W=4: deliver 17 samples -> out_count=1.
